bp_mem_noc_dram_responder: RTL and testbench
============================================

Name: bp_mem_noc_dram_responder

Overview:
Memory-side endpoint of the mem NoC DRAM link. It accepts wormhole command packets that a processor drives on its DRAM command link, and services reads and writes against an internal flit-wide memory array. It returns wormhole response packets on the paired response link. Used as the DRAM model and terminus in processor-level testbenches and FPGA shells.

Parameters:
flit_width_p, 128, mem NoC flit width in bits; multiple of 8, at least 80.
cord_width_p, 8, destination/source cord width.
len_width_p, 4, wormhole length field width (count of data flits after the header).
paddr_width_p, 40, physical address width.
els_p, 1024, memory depth in flit-wide words; power of 2.

Ports:
clk_i  in  1  clock.
reset_i  in  1  asynchronous, active-high reset.
cmd_link_i  in  flit_width_p+2  ready_and link struct {v, data, ready_and_rev}. v/data carry command flits. ready_and_rev is the far side's ready for our response flits.
resp_link_o  out  flit_width_p+2  {v, data, ready_and_rev}. v/data carry response flits. ready_and_rev is our ready for command flits.

Behaviour:
- Header flit fields, LSB first:
  - dst_cord[cord_width_p]
  - len[len_width_p]
  - msg_type[4]: 0 = read, 1 = write, other = unsupported
  - size[3]: 2^size bytes, 0..6
  - addr[paddr_width_p]
  - src_cord[cord_width_p]
  - remaining bits are 0.
- Data flit count N = max(1, (8<<size)/flit_width_p). A size above 6 is treated as 6.
- Word index = addr[log2(flit_width_p/8) +: log2(els_p)]. Flit k of a packet uses index (base+k) mod els_p, so it wraps at the end of the array.
- A flit transfers on any cycle where v & ready are both 1.
- FSM states: IDLE, RECV, ACCESS, SEND_HDR, SEND_DATA.
  - IDLE: ready_and_rev=1. On a header transfer, latch the fields. If len>0, go to RECV; otherwise go to ACCESS.
  - RECV: ready_and_rev=1. Each transfer is one write-data flit, buffered in a len-deep register file. After the flit numbered len, go to ACCESS.
  - ACCESS: one cycle.
    - Write: commit the buffered flits. If size<4 (sub-flit), write only the byte lanes [addr mod flit_bytes, +2^size) and take data from the same lanes. Consume the received flits in order; if len≠N, write min(len,N) flits.
    - Read: fetch N words into a response buffer.
    - Unsupported type: the array is untouched.
  - SEND_HDR: v=1, data = {src_cord as dst_cord, resp len, msg_type, size, addr, dst_cord as src_cord}. resp len = N for read, 0 otherwise. Hold v and data stable until ready. Then go to SEND_DATA if resp len>0, else IDLE.
  - SEND_DATA: stream N read words in index order, each held stable until accepted. After the last one, go to IDLE.
- ready_and_rev=0 in ACCESS, SEND_HDR and SEND_DATA; only one packet is outstanding.
- Minimum latency, header accepted to response header valid: 2 cycles for a read; len+2 cycles for a write when data arrives back-to-back.
- Reset (asynchronous, any state): FSM goes to IDLE and resp_link_o is all zero in the reset cycle. Command ready rises the first cycle after reset deasserts. Memory contents are not reset, and the array never drives X onto resp_link_o.data when v=0; data is 0 while v=0.
- A header arriving while the block is not ready is not accepted; the sender holds it.

Optional Feature:
BP_DRAM_RESP_DELAY_EN
- Defined: adds parameter delay_p (default 16) and a DELAY state between ACCESS and SEND_HDR. A down-counter loaded with delay_p must reach 0 before SEND_HDR. With delay_p=0 the delay is 0 extra cycles.
- Undefined: no counter and no DELAY state; ACCESS goes directly to SEND_HDR.

Test Plan:
- Write then read, 64B (size=6, flit 128, N=4):
  - Write header addr 0x1000, src_cord 3, followed by 4 data flits A0..A3 -> response header {dst_cord 3, len 0, type 1}.
  - Read of the same address -> header with len 4, followed by data A0..A3 in order.
- Sub-flit write: 4B value 0xDEADBEEF to addr 0x1004 over a word previously all 0x11 -> a 16B read returns bytes 4..7 = EF BE AD DE and all other bytes 0x11.
- Wrap: 64B write at the last word index (els_p-1) -> flits land at indices els_p-1, 0, 1, 2; a read from index 0 returns flits 2..4 of the write.
- Backpressure: hold cmd_link_i.ready_and_rev=0 for 10 cycles during SEND_DATA -> v stays 1 and data stays unchanged; no flit is lost or duplicated.
- Reset mid-RECV after 2 of 4 write flits -> the outputs are 0 and the block returns to IDLE. A subsequent read returns the previous contents, because the partial write is never committed.
- Unsupported msg_type 5 -> response header only (len 0, type 5) and the memory is unchanged.

Source files
------------

// File: rtl/bp_mem_noc_dram_responder.sv
// bp_mem_noc_dram_responder: memory-side endpoint of the mem NoC DRAM link.
// Accepts wormhole command packets (header + optional write data flits),
// services reads/writes against a flit-wide memory array, and returns a
// wormhole response packet (header + read data flits).
// Link layout, MSB first: {v, data[flit_width_p-1:0], ready_and_rev}.
// Optional feature macro BP_DRAM_RESP_DELAY_EN: adds parameter delay_p and a
// DELAY state that holds the response for delay_p cycles after ACCESS.
module bp_mem_noc_dram_responder #(
    parameter int flit_width_p  = 128,
    parameter int cord_width_p  = 8,
    parameter int len_width_p   = 4,
    parameter int paddr_width_p = 40,
    parameter int els_p         = 1024
`ifdef BP_DRAM_RESP_DELAY_EN
    , parameter int delay_p     = 16
`endif
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [flit_width_p+1:0] cmd_link_i,
    output logic [flit_width_p+1:0] resp_link_o
);

    localparam int FLIT_BYTES = flit_width_p / 8;
    localparam int OFF_W      = $clog2(FLIT_BYTES);
    localparam int IDX_W      = $clog2(els_p);
    // Largest packet is 64B; a packet never needs more than this many flits.
    localparam int MAX_N      = (512 / flit_width_p > 0) ? 512 / flit_width_p : 1;
    localparam int LEN_MAX    = (1 << len_width_p) - 1;
    localparam int WBUF_D     = (LEN_MAX > MAX_N) ? LEN_MAX : MAX_N;
    localparam int CNT_W      = (len_width_p > 3) ? len_width_p : 3;

    // Header field positions, LSB first.
    localparam int LEN_LSB  = cord_width_p;
    localparam int TYPE_LSB = LEN_LSB + len_width_p;
    localparam int SIZE_LSB = TYPE_LSB + 4;
    localparam int ADDR_LSB = SIZE_LSB + 3;
    localparam int SRC_LSB  = ADDR_LSB + paddr_width_p;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_ACCESS,
        S_SEND_HDR,
        S_SEND_DATA
`ifdef BP_DRAM_RESP_DELAY_EN
        , S_DELAY
`endif
    } state_e;

    state_e state;

    logic                    cmd_v;
    logic [flit_width_p-1:0] cmd_data;
    logic                    resp_ready;
    logic                    cmd_fire;
    logic                    resp_fire;

    logic                    v_r;
    logic [flit_width_p-1:0] data_r;
    logic                    rdy_r;

    logic [cord_width_p-1:0]  h_dst;
    logic [len_width_p-1:0]   h_len;
    logic [3:0]               h_type;
    logic [2:0]               h_size;
    logic [paddr_width_p-1:0] h_addr;
    logic [cord_width_p-1:0]  h_src;

    logic [len_width_p-1:0] rcv_cnt;
    logic [CNT_W-1:0]       snd_cnt;
`ifdef BP_DRAM_RESP_DELAY_EN
    logic [31:0]            dly_cnt;
`endif

    logic [2:0]              sz_c;
    logic [CNT_W-1:0]        nflits;
    logic [CNT_W-1:0]        wr_cnt;
    logic [len_width_p-1:0]  resp_len;
    logic                    is_rd;
    logic                    is_wr;
    logic                    sub;
    logic [OFF_W-1:0]        off;
    logic [IDX_W-1:0]        base;
    logic [FLIT_BYTES-1:0]   be;
    logic [flit_width_p-1:0] resp_hdr;
    logic [flit_width_p-1:0] rbuf_sel;

    logic [flit_width_p-1:0] mem  [els_p];
    logic [flit_width_p-1:0] wbuf [WBUF_D];
    logic [flit_width_p-1:0] rbuf [MAX_N];

    assign cmd_v      = cmd_link_i[flit_width_p+1];
    assign cmd_data   = cmd_link_i[flit_width_p:1];
    assign resp_ready = cmd_link_i[0];
    assign cmd_fire   = cmd_v & rdy_r;
    assign resp_fire  = v_r & resp_ready;

    assign resp_link_o = {v_r, data_r, rdy_r};

    assign sz_c     = (h_size > 3'd6) ? 3'd6 : h_size;
    assign is_rd    = (h_type == 4'd0);
    assign is_wr    = (h_type == 4'd1);
    assign resp_len = is_rd ? len_width_p'(nflits) : '0;
    assign wr_cnt   = (CNT_W'(h_len) < nflits) ? CNT_W'(h_len) : nflits;
    assign base     = h_addr[OFF_W +: IDX_W];
    assign off      = OFF_W'(h_addr % paddr_width_p'(FLIT_BYTES));
    assign sub      = ((1 << sz_c) < FLIT_BYTES);

    // Data flit count from the (clamped) size; sub-flit sizes still take one flit.
    always_comb begin
        nflits = CNT_W'((32'd8 << sz_c) / flit_width_p);
        if (nflits == '0) nflits = CNT_W'(1);
    end

    // Byte enables: full flit, or only the addressed lanes for sub-flit writes.
    always_comb begin
        for (int b = 0; b < FLIT_BYTES; b++)
            be[b] = !sub || ((b >= int'(off)) && (b < int'(off) + (1 << sz_c)));
    end

    // Response header: cords swapped, length reflects read data count.
    always_comb begin
        resp_hdr = '0;
        resp_hdr[0 +: cord_width_p]         = h_src;
        resp_hdr[LEN_LSB +: len_width_p]    = resp_len;
        resp_hdr[TYPE_LSB +: 4]             = h_type;
        resp_hdr[SIZE_LSB +: 3]             = h_size;
        resp_hdr[ADDR_LSB +: paddr_width_p] = h_addr;
        resp_hdr[SRC_LSB +: cord_width_p]   = h_dst;
    end

    // Select the next read flit to stream out.
    always_comb begin
        rbuf_sel = '0;
        for (int k = 0; k < MAX_N; k++)
            if (CNT_W'(k) == snd_cnt) rbuf_sel = rbuf[k];
    end

    // Storage: write-data buffer, memory array and read buffer (never reset).
    always_ff @(posedge clk_i) begin
        if (state == S_RECV && cmd_fire) begin
            for (int k = 0; k < WBUF_D; k++)
                if (CNT_W'(k) == CNT_W'(rcv_cnt)) wbuf[k] <= cmd_data;
        end
        if (state == S_ACCESS) begin
            if (is_wr) begin
                for (int k = 0; k < MAX_N; k++)
                    if (CNT_W'(k) < wr_cnt)
                        for (int b = 0; b < FLIT_BYTES; b++)
                            if (be[b]) mem[base + IDX_W'(k)][8*b +: 8] <= wbuf[k][8*b +: 8];
            end
            if (is_rd) begin
                for (int k = 0; k < MAX_N; k++)
                    rbuf[k] <= mem[base + IDX_W'(k)];
            end
        end
    end

    // Packet FSM with registered link outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= S_IDLE;
            v_r     <= 1'b0;
            data_r  <= '0;
            rdy_r   <= 1'b0;
            h_dst   <= '0;
            h_len   <= '0;
            h_type  <= '0;
            h_size  <= '0;
            h_addr  <= '0;
            h_src   <= '0;
            rcv_cnt <= '0;
            snd_cnt <= '0;
`ifdef BP_DRAM_RESP_DELAY_EN
            dly_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    v_r    <= 1'b0;
                    data_r <= '0;
                    rdy_r  <= 1'b1;
                    if (cmd_fire) begin
                        h_dst   <= cmd_data[0 +: cord_width_p];
                        h_len   <= cmd_data[LEN_LSB +: len_width_p];
                        h_type  <= cmd_data[TYPE_LSB +: 4];
                        h_size  <= cmd_data[SIZE_LSB +: 3];
                        h_addr  <= cmd_data[ADDR_LSB +: paddr_width_p];
                        h_src   <= cmd_data[SRC_LSB +: cord_width_p];
                        rcv_cnt <= '0;
                        if (cmd_data[LEN_LSB +: len_width_p] != '0) begin
                            state <= S_RECV;
                        end else begin
                            state <= S_ACCESS;
                            rdy_r <= 1'b0;
                        end
                    end
                end
                S_RECV: begin
                    if (cmd_fire) begin
                        rcv_cnt <= rcv_cnt + 1'b1;
                        if (rcv_cnt == h_len - 1'b1) begin
                            state <= S_ACCESS;
                            rdy_r <= 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    snd_cnt <= '0;
`ifdef BP_DRAM_RESP_DELAY_EN
                    if (delay_p == 0) begin
                        state  <= S_SEND_HDR;
                        v_r    <= 1'b1;
                        data_r <= resp_hdr;
                    end else begin
                        dly_cnt <= 32'(delay_p - 1);
                        state   <= S_DELAY;
                    end
`else
                    state  <= S_SEND_HDR;
                    v_r    <= 1'b1;
                    data_r <= resp_hdr;
`endif
                end
`ifdef BP_DRAM_RESP_DELAY_EN
                S_DELAY: begin
                    if (dly_cnt == '0) begin
                        state  <= S_SEND_HDR;
                        v_r    <= 1'b1;
                        data_r <= resp_hdr;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
`endif
                S_SEND_HDR: begin
                    if (resp_fire) begin
                        if (resp_len != '0) begin
                            state   <= S_SEND_DATA;
                            data_r  <= rbuf[0];
                            snd_cnt <= CNT_W'(1);
                        end else begin
                            state  <= S_IDLE;
                            v_r    <= 1'b0;
                            data_r <= '0;
                            rdy_r  <= 1'b1;
                        end
                    end
                end
                S_SEND_DATA: begin
                    if (resp_fire) begin
                        if (snd_cnt == nflits) begin
                            state  <= S_IDLE;
                            v_r    <= 1'b0;
                            data_r <= '0;
                            rdy_r  <= 1'b1;
                        end else begin
                            data_r  <= rbuf_sel;
                            snd_cnt <= snd_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    v_r    <= 1'b0;
                    data_r <= '0;
                    rdy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_mem_noc_dram_responder.sv
// Directed bench for bp_mem_noc_dram_responder (default parameters).
module tb_bp_mem_noc_dram_responder;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_v;
    logic [W-1:0] cmd_data;
    logic         resp_rdy;
    logic [W+1:0] cmd_link;
    logic [W+1:0] resp_link;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] a [4];
    logic [W-1:0] w [4];
    logic [W-1:0] kv;
    logic [W-1:0] m0;

    assign cmd_link = {cmd_v, cmd_data, resp_rdy};

    always #5 clk = ~clk;

    bp_mem_noc_dram_responder dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .cmd_link_i (cmd_link),
        .resp_link_o(resp_link)
    );

    task automatic chk(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] hdr(input logic [7:0] dst, input logic [3:0] len,
                                         input logic [3:0] typ, input logic [2:0] sz,
                                         input logic [39:0] addr, input logic [7:0] src);
        logic [W-1:0] h;
        h = '0;
        h[7:0]   = dst;
        h[11:8]  = len;
        h[15:12] = typ;
        h[18:16] = sz;
        h[58:19] = addr;
        h[66:59] = src;
        return h;
    endfunction

    task automatic send(input logic [W-1:0] d);
        int n;
        n = 0;
        cmd_v    = 1'b1;
        cmd_data = d;
        @(negedge clk);
        while (!resp_link[0] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_v    = 1'b0;
        cmd_data = '0;
    endtask

    task automatic recv(output logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_link[W+1] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("recv_timeout", 0, 1);
        d = resp_link[W:1];
        @(posedge clk);
        #1;
    endtask

    task automatic expect_flit(input string tag, input logic [W-1:0] e);
        logic [W-1:0] d;
        recv(d);
        chk(tag, {2'b00, d}, {2'b00, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            a[k] = {32'hA0A0_0000 + 32'(k), 32'h1234_5678, 32'h0BAD_F00D, 32'hA000_0000 + 32'(k)};
            w[k] = {32'h5757_0000 + 32'(k), 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h5700_0000 + 32'(k)};
        end
        kv = 128'h4B4B4B4B_00000003_4B4B4B4B_00000003;
        m0 = 128'h11111111_11111111_DEADBEEF_11111111;

        cmd_v = 1'b0; cmd_data = '0; resp_rdy = 1'b1; rst = 1'b1;

        // reset state and ready rise
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_zero", resp_link, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_low_first_cycle", {131'b0, resp_link[0]}, '0);
        @(posedge clk);
        #1;
        chk("rdy_rises", {131'b0, resp_link[0]}, 1);

        // 64B write at 0x1000
        send(hdr(8'd1, 4'd4, 4'd1, 3'd6, 40'h1000, 8'd3));
        for (int k = 0; k < 4; k++) send(a[k]);
        expect_flit("wr64_hdr", hdr(8'd3, 4'd0, 4'd1, 3'd6, 40'h1000, 8'd1));

        // 64B read back
        send(hdr(8'd1, 4'd0, 4'd0, 3'd6, 40'h1000, 8'd3));
        expect_flit("rd64_hdr", hdr(8'd3, 4'd4, 4'd0, 3'd6, 40'h1000, 8'd1));
        for (int k = 0; k < 4; k++) expect_flit($sformatf("rd64_d%0d", k), a[k]);

        // sub-flit write over a word of 0x11
        send(hdr(8'd1, 4'd1, 4'd1, 3'd4, 40'h1000, 8'd3));
        send({4{32'h1111_1111}});
        expect_flit("wr16_hdr", hdr(8'd3, 4'd0, 4'd1, 3'd4, 40'h1000, 8'd1));
        send(hdr(8'd1, 4'd1, 4'd1, 3'd2, 40'h1004, 8'd3));
        send(128'hCCCCCCCC_CCCCCCCC_DEADBEEF_CCCCCCCC);
        expect_flit("wr4_hdr", hdr(8'd3, 4'd0, 4'd1, 3'd2, 40'h1004, 8'd1));
        send(hdr(8'd1, 4'd0, 4'd0, 3'd4, 40'h1000, 8'd3));
        expect_flit("rd16_hdr", hdr(8'd3, 4'd1, 4'd0, 3'd4, 40'h1000, 8'd1));
        expect_flit("rd16_merged", m0);

        // wrap at the end of the array
        send(hdr(8'd1, 4'd1, 4'd1, 3'd4, 40'h30, 8'd3));
        send(kv);
        expect_flit("wr_idx3_hdr", hdr(8'd3, 4'd0, 4'd1, 3'd4, 40'h30, 8'd1));
        send(hdr(8'd1, 4'd4, 4'd1, 3'd6, 40'h3FF0, 8'd3));
        for (int k = 0; k < 4; k++) send(w[k]);
        expect_flit("wrap_wr_hdr", hdr(8'd3, 4'd0, 4'd1, 3'd6, 40'h3FF0, 8'd1));
        send(hdr(8'd1, 4'd0, 4'd0, 3'd6, 40'h0, 8'd3));
        expect_flit("wrap_rd_hdr", hdr(8'd3, 4'd4, 4'd0, 3'd6, 40'h0, 8'd1));
        expect_flit("wrap_idx0", w[1]);
        expect_flit("wrap_idx1", w[2]);
        expect_flit("wrap_idx2", w[3]);
        expect_flit("wrap_idx3_untouched", kv);
        send(hdr(8'd1, 4'd0, 4'd0, 3'd4, 40'h3FF0, 8'd3));
        expect_flit("last_rd_hdr", hdr(8'd3, 4'd1, 4'd0, 3'd4, 40'h3FF0, 8'd1));
        expect_flit("last_idx", w[0]);

        // backpressure during SEND_DATA
        send(hdr(8'd1, 4'd0, 4'd0, 3'd6, 40'h1000, 8'd3));
        expect_flit("bp_hdr", hdr(8'd3, 4'd4, 4'd0, 3'd6, 40'h1000, 8'd1));
        resp_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_%0d", c), {1'b0, resp_link[W+1:1]}, {2'b01, m0});
        end
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        expect_flit("bp_d0", m0);
        for (int k = 1; k < 4; k++) expect_flit($sformatf("bp_d%0d", k), a[k]);
        @(negedge clk);
        chk("bp_no_extra", resp_link, 1);

        // reset in the middle of a write packet
        send(hdr(8'd1, 4'd4, 4'd1, 3'd6, 40'h1000, 8'd3));
        send(w[0]);
        send(w[1]);
        rst = 1'b1;
        #1;
        chk("mid_recv_reset_out", resp_link, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(hdr(8'd1, 4'd0, 4'd0, 3'd6, 40'h1000, 8'd3));
        expect_flit("post_rst_hdr", hdr(8'd3, 4'd4, 4'd0, 3'd6, 40'h1000, 8'd1));
        expect_flit("post_rst_d0", m0);
        for (int k = 1; k < 4; k++) expect_flit($sformatf("post_rst_d%0d", k), a[k]);

        // unsupported message type
        send(hdr(8'd1, 4'd0, 4'd5, 3'd6, 40'h1000, 8'd3));
        expect_flit("unsup_hdr", hdr(8'd3, 4'd0, 4'd5, 3'd6, 40'h1000, 8'd1));
        @(negedge clk);
        chk("unsup_no_data", {131'b0, resp_link[W+1]}, '0);
        send(hdr(8'd1, 4'd0, 4'd0, 3'd4, 40'h1000, 8'd3));
        expect_flit("unsup_rd_hdr", hdr(8'd3, 4'd1, 4'd0, 3'd4, 40'h1000, 8'd1));
        expect_flit("unsup_mem_kept", m0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
